// File: rtl/jpeg_sync_fifo.sv
// Parametrised synchronous FIFO for the JPEG encoder datapath.
// Extra-MSB pointers, standard or first-word-fall-through read, sticky error flags.
module jpeg_sync_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter bit FWFT      = 1'b0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_req,
  output logic [DATA_W-1:0] read_data,
  output logic              rdata_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clear
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_L    = (AW+1)'(AE_THRESH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              rd_acc, wr_acc;
  logic [AW-1:0]     waddr, raddr;

  assign waddr        = wptr_q[AW-1:0];
  assign raddr        = rptr_q[AW-1:0];
  assign level        = wptr_q - rptr_q;
  assign fifo_empty   = (level == '0);
  assign fifo_full    = (level == DEPTH_L);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A write into a full FIFO is legal only when a pop frees a slot in the same cycle.
  assign rd_acc = read_req & ~fifo_empty;
  assign wr_acc = write_enable & (~fifo_full | rd_acc);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_acc)                     wptr_d      = wptr_q + ONE_L;
      if (rd_acc)                     rptr_d      = rptr_q + ONE_L;
      if (write_enable && !wr_acc)    overflow_d  = 1'b1;
      if (read_req && fifo_empty)     underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc) mem_q[waddr] <= write_data;
  end

  generate
    if (FWFT) begin : g_fwft
      assign read_data   = mem_q[raddr];
      assign rdata_valid = ~fifo_empty;
    end else begin : g_std
      logic [DATA_W-1:0] rdata_q;
      logic              rvalid_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else if (flush) begin
          rvalid_q <= 1'b0;
        end else if (rd_acc) begin
          rdata_q  <= mem_q[raddr];
          rvalid_q <= 1'b1;
        end else begin
          rvalid_q <= 1'b0;
        end
      end
      assign read_data   = rdata_q;
      assign rdata_valid = rvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_jpeg_sync_fifo.sv
// Bench for jpeg_sync_fifo: standard and FWFT instances on shared stimulus,
// both compared every cycle against a queue-based reference model.
module tb_jpeg_sync_fifo;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int AF = 6;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst, flush, write_enable, read_req, err_clear;
  logic [DW-1:0] write_data;

  logic [DW-1:0] rd_s, rd_f;
  logic rv_s, rv_f, emp_s, emp_f, ful_s, ful_f, af_s, af_f, ae_s, ae_f;
  logic ovf_s, ovf_f, uf_s, uf_f;
  logic [AW:0] lvl_s, lvl_f;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [DW-1:0] q[$];
  logic m_ovf, m_uf, m_rv;
  logic [DW-1:0] m_rd;

  always #5 clk = ~clk;

  jpeg_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1'b0), .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .write_enable(write_enable), .write_data(write_data),
    .read_req(read_req), .read_data(rd_s), .rdata_valid(rv_s), .fifo_empty(emp_s),
    .fifo_full(ful_s), .almost_full(af_s), .almost_empty(ae_s), .level(lvl_s),
    .overflow(ovf_s), .underflow(uf_s), .err_clear(err_clear));

  jpeg_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1'b1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .write_enable(write_enable), .write_data(write_data),
    .read_req(read_req), .read_data(rd_f), .rdata_valid(rv_f), .fifo_empty(emp_f),
    .fifo_full(ful_f), .almost_full(af_f), .almost_empty(ae_f), .level(lvl_f),
    .overflow(ovf_f), .underflow(uf_f), .err_clear(err_clear));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Advance the reference by one clock using the spec's acceptance rules.
  task automatic model_step();
    bit emp, ful, rd_acc, wr_acc;
    emp = (q.size() == 0);
    ful = (q.size() == DEPTH);
    if (rst) begin
      q.delete();
      m_ovf = 0; m_uf = 0; m_rv = 0; m_rd = '0;
    end else begin
      if (err_clear) begin m_ovf = 0; m_uf = 0; end
      if (flush) begin
        q.delete();
        m_rv = 0;
      end else begin
        rd_acc = read_req && !emp;
        wr_acc = write_enable && (!ful || rd_acc);
        if (rd_acc) begin m_rd = q.pop_front(); m_rv = 1; end
        else m_rv = 0;
        if (wr_acc) q.push_back(write_data);
        if (write_enable && !wr_acc) m_ovf = 1;
        if (read_req && emp) m_uf = 1;
      end
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("level_s", 32'(lvl_s), 32'(n));
    chk("level_f", 32'(lvl_f), 32'(n));
    chk("empty_s", 32'(emp_s), 32'(n == 0));
    chk("empty_f", 32'(emp_f), 32'(n == 0));
    chk("full_s", 32'(ful_s), 32'(n == DEPTH));
    chk("full_f", 32'(ful_f), 32'(n == DEPTH));
    chk("afull_s", 32'(af_s), 32'(n >= AF));
    chk("afull_f", 32'(af_f), 32'(n >= AF));
    chk("aempty_s", 32'(ae_s), 32'(n <= AE));
    chk("aempty_f", 32'(ae_f), 32'(n <= AE));
    chk("ovf_s", 32'(ovf_s), 32'(m_ovf));
    chk("ovf_f", 32'(ovf_f), 32'(m_ovf));
    chk("uf_s", 32'(uf_s), 32'(m_uf));
    chk("uf_f", 32'(uf_f), 32'(m_uf));
    chk("rvalid_s", 32'(rv_s), 32'(m_rv));
    chk("rdata_s", 32'(rd_s), 32'(m_rd));
    chk("rvalid_f", 32'(rv_f), 32'(n != 0));
    if (n != 0) chk("rdata_f", 32'(rd_f), 32'(q[0]));
  endtask

  task automatic cyc(input logic we, input logic [DW-1:0] wd, input logic rr,
                     input logic fl, input logic ec, input logic rs);
    write_enable = we; write_data = wd; read_req = rr;
    flush = fl; err_clear = ec; rst = rs;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1; flush = 0; write_enable = 0; read_req = 0; err_clear = 0; write_data = '0;
    q.delete(); m_ovf = 0; m_uf = 0; m_rv = 0; m_rd = '0;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // basic three-word ordering
    cyc(1, 16'h11, 0, 0, 0, 0);
    cyc(1, 16'h22, 0, 0, 0, 0);
    cyc(1, 16'h33, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) cyc(1, DW'(i), 0, 0, 0, 0);
    cyc(1, 16'hDEAD, 0, 0, 0, 0);
    repeat (DEPTH) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // full with simultaneous read and write across pointer wrap
    for (int i = 0; i < DEPTH; i++) cyc(1, DW'(16'h100 + i), 0, 0, 0, 0);
    for (int i = 0; i < 2 * DEPTH; i++) cyc(1, DW'(16'h200 + i), 1, 0, 0, 0);
    repeat (DEPTH) cyc(0, 0, 1, 0, 0, 0);

    // underflow and err_clear precedence
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(1, 16'h0A5, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);

    // flush with a concurrent write at level 5
    for (int i = 0; i < 5; i++) cyc(1, DW'(16'h300 + i), 0, 0, 0, 0);
    cyc(1, 16'hBEEF, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // mid-stream reset
    for (int i = 0; i < 4; i++) cyc(1, DW'(16'h400 + i), 0, 0, 0, 0);
    cyc(1, 16'h4FF, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);

    // randomized traffic with drifting write/read bias
    for (int i = 0; i < 3000; i++) begin
      int wbias;
      logic fl, ec;
      wbias = ((i / 200) % 2 == 0) ? 70 : 30;
      fl = ($urandom_range(0, 63) == 0);
      ec = fl ? 1'b0 : ($urandom_range(0, 15) == 0);
      cyc(($urandom_range(0, 99) < wbias), DW'($urandom), ($urandom_range(0, 99) < 50),
          fl, ec, ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
